snn_layer_tm: RTL and testbench

Time-multiplexed, fully parametrised leaky-integrate-and-fire layer. It replaces hand-instantiated fixed-weight neuron networks with one shared accumulate/update datapath. The datapath serves N_OUT neurons fed by N_IN input spikes, with weights in a runtime-writable register file. Layers chain step-by-step through a valid/ready handshake, giving a configurable feed-forward SNN.

---
 rtl/snn_layer_tm_if.sv | 29 ++
 rtl/snn_layer_tm.sv | 174 +++++++++++++++++
 tb/tb_snn_layer_tm.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/snn_layer_tm_if.sv
// Step handshake, weight-write port and spike I/O of one time-multiplexed LIF layer.
interface snn_layer_tm_if #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned N_OUT  = 3,
    parameter int unsigned V_SIZE = 8
) ();
    localparam int unsigned IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     w_we;
    logic [IW-1:0]            w_addr_in;
    logic [JW-1:0]            w_addr_out;
    logic signed [V_SIZE-1:0] w_data;
    logic                     step_valid;
    logic                     step_ready;
    logic [N_IN-1:0]          spike_in;
    logic                     out_valid;
    logic [N_OUT-1:0]         spike_out;

    modport master (
        output w_we, w_addr_in, w_addr_out, w_data, step_valid, spike_in,
        input  step_ready, out_valid, spike_out
    );

    modport slave (
        input  w_we, w_addr_in, w_addr_out, w_data, step_valid, spike_in,
        output step_ready, out_valid, spike_out
    );
endinterface

// File: rtl/snn_layer_tm.sv
// Leaky-integrate-and-fire layer: N_OUT neurons share one accumulate/update datapath,
// one input per cycle, weights held in a runtime-writable register file.
module snn_layer_tm #(
    parameter int unsigned N_IN       = 3,
    parameter int unsigned N_OUT      = 3,
    parameter int unsigned V_SIZE     = 8,
    parameter int          THRESH     = 8,
    parameter int unsigned LEAK_SHIFT = 1,
    parameter int unsigned REFRAC     = 0
) (
    input  logic           clk,
    input  logic           rst,
    snn_layer_tm_if.slave  bus
);
    localparam int unsigned IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned AW = V_SIZE + $clog2(N_IN) + 1;
    localparam int unsigned SW = AW + 2;
    localparam int unsigned RW = 8;

    localparam logic signed [SW-1:0]     V_MAX = SW'((2 ** (V_SIZE - 1)) - 1);
    localparam logic signed [SW-1:0]     V_MIN = SW'(-(2 ** (V_SIZE - 1)));
    localparam logic signed [V_SIZE-1:0] TH    = V_SIZE'(THRESH);
    localparam logic [IW-1:0]            I_LAST = IW'(N_IN - 1);
    localparam logic [JW-1:0]            J_LAST = JW'(N_OUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE, S_DONE} state_t;

    state_t                   state;
    logic                     ready;
    logic                     out_valid_q;
    logic [N_OUT-1:0]         spike_out_q;
    logic [N_OUT-1:0]         spike_nxt;
    logic [N_IN-1:0]          spike_in_q;
    logic [IW-1:0]            i_idx;
    logic [JW-1:0]            j_idx;
    logic signed [AW-1:0]     acc;
    logic signed [V_SIZE-1:0] w   [N_IN][N_OUT];
    logic signed [V_SIZE-1:0] v   [N_OUT];
    logic [RW-1:0]            refc [N_OUT];

    // Pre-write copy of a weight written on the accepting edge, so that step sees the old value
    logic                     byp_valid;
    logic [IW-1:0]            byp_i;
    logic [JW-1:0]            byp_j;
    logic signed [V_SIZE-1:0] byp_w;

    logic                     wr_hit;
    logic signed [V_SIZE-1:0] w_rd;
    logic signed [V_SIZE-1:0] w_term;
    logic signed [V_SIZE-1:0] v_cur;
    logic signed [V_SIZE-1:0] leak;
    logic signed [SW-1:0]     v_sum;
    logic signed [V_SIZE-1:0] v_sat;
    logic                     fire;

    // Weight read, leak/integrate with saturation, and threshold compare for the current neuron
    always_comb begin
        wr_hit = bus.w_we && ready
                 && (32'(bus.w_addr_in)  < 32'(N_IN))
                 && (32'(bus.w_addr_out) < 32'(N_OUT));
        w_rd   = w[i_idx][j_idx];
        if (byp_valid && (byp_i == i_idx) && (byp_j == j_idx)) begin
            w_rd = byp_w;
        end
        w_term = spike_in_q[i_idx] ? w_rd : '0;
        v_cur  = v[j_idx];
        leak   = v_cur >>> LEAK_SHIFT;
        v_sum  = SW'(v_cur) - SW'(leak) + SW'(acc);
        if (v_sum > V_MAX) begin
            v_sat = V_SIZE'(V_MAX);
        end else if (v_sum < V_MIN) begin
            v_sat = V_SIZE'(V_MIN);
        end else begin
            v_sat = V_SIZE'(v_sum);
        end
        fire = (v_sat >= TH);
    end

    // Step FSM, weight file, membrane and refractory state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ready       <= 1'b1;
            out_valid_q <= 1'b0;
            spike_out_q <= '0;
            spike_nxt   <= '0;
            spike_in_q  <= '0;
            i_idx       <= '0;
            j_idx       <= '0;
            acc         <= '0;
            byp_valid   <= 1'b0;
            byp_i       <= '0;
            byp_j       <= '0;
            byp_w       <= '0;
            for (int a = 0; a < N_IN; a++) begin
                for (int b = 0; b < N_OUT; b++) begin
                    w[a][b] <= '0;
                end
            end
            for (int b = 0; b < N_OUT; b++) begin
                v[b]    <= '0;
                refc[b] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (wr_hit) begin
                w[bus.w_addr_in][bus.w_addr_out] <= bus.w_data;
            end
            case (state)
                S_IDLE: begin
                    if (bus.step_valid) begin
                        spike_in_q <= bus.spike_in;
                        i_idx      <= '0;
                        j_idx      <= '0;
                        acc        <= '0;
                        ready      <= 1'b0;
                        byp_valid  <= wr_hit;
                        if (wr_hit) begin
                            byp_i <= bus.w_addr_in;
                            byp_j <= bus.w_addr_out;
                            byp_w <= w[bus.w_addr_in][bus.w_addr_out];
                        end
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc + AW'(w_term);
                    if (i_idx == I_LAST) begin
                        state <= S_UPDATE;
                    end else begin
                        i_idx <= i_idx + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (refc[j_idx] != '0) begin
                        refc[j_idx]      <= refc[j_idx] - 1'b1;
                        v[j_idx]         <= '0;
                        spike_nxt[j_idx] <= 1'b0;
                    end else if (fire) begin
                        spike_nxt[j_idx] <= 1'b1;
                        v[j_idx]         <= '0;
                        refc[j_idx]      <= RW'(REFRAC);
                    end else begin
                        v[j_idx]         <= v_sat;
                        spike_nxt[j_idx] <= 1'b0;
                    end
                    if (j_idx == J_LAST) begin
                        state <= S_DONE;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                        i_idx <= '0;
                        acc   <= '0;
                        state <= S_ACCUM;
                    end
                end
                S_DONE: begin
                    spike_out_q <= spike_nxt;
                    out_valid_q <= 1'b1;
                    ready       <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.step_ready = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.spike_out  = spike_out_q;
endmodule

// File: tb/tb_snn_layer_tm.sv
// Directed bench for snn_layer_tm: a step table plus hand-written busy/abort/same-edge sequences.
// dut0 runs with REFRAC=0, dut2 with REFRAC=2; both see identical stimulus.
module tb_snn_layer_tm;
    localparam int L = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_we = 1'b0;
    logic [1:0] w_addr_in = '0;
    logic [0:0] w_addr_out = '0;
    logic [7:0] w_data = '0;
    logic       step_valid = 1'b0;
    logic [2:0] spike_in = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    snn_layer_tm_if #(.N_IN(3), .N_OUT(2), .V_SIZE(8)) b0 ();
    snn_layer_tm_if #(.N_IN(3), .N_OUT(2), .V_SIZE(8)) b2 ();

    assign b0.w_we = w_we;             assign b2.w_we = w_we;
    assign b0.w_addr_in = w_addr_in;   assign b2.w_addr_in = w_addr_in;
    assign b0.w_addr_out = w_addr_out; assign b2.w_addr_out = w_addr_out;
    assign b0.w_data = w_data;         assign b2.w_data = w_data;
    assign b0.step_valid = step_valid; assign b2.step_valid = step_valid;
    assign b0.spike_in = spike_in;     assign b2.spike_in = spike_in;

    snn_layer_tm #(.N_IN(3), .N_OUT(2), .V_SIZE(8), .THRESH(8), .LEAK_SHIFT(1), .REFRAC(0))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    snn_layer_tm #(.N_IN(3), .N_OUT(2), .V_SIZE(8), .THRESH(8), .LEAK_SHIFT(1), .REFRAC(2))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        bit         rst;
        bit         we;
        int         wi;
        int         wj;
        int         wd;
        bit         step;
        logic [2:0] sin;
        logic [1:0] exp0;
        bit         chk2;
        logic [1:0] exp2;
        bit         chkv;
        int         vj;
        int         expv;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic wr(input int wi, input int wj, input int wd);
        @(negedge clk);
        w_we = 1'b1; w_addr_in = 2'(wi); w_addr_out = 1'(wj); w_data = 8'(wd);
        @(negedge clk);
        w_we = 1'b0;
    endtask

    // Wait (bounded) for out_valid after an accept; lat = edges after accept, -1 on timeout
    task automatic wait_done(output int lat, output bit busy_ok,
                             output logic [1:0] sp0, output logic [1:0] sp2);
        lat = -1; busy_ok = 1'b1; sp0 = 'x; sp2 = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (b0.out_valid) begin
                lat = k; sp0 = b0.spike_out; sp2 = b2.spike_out;
                break;
            end
            if (b0.step_ready) busy_ok = 1'b0;
        end
    endtask

    task automatic do_step(input logic [2:0] s, output int lat, output bit busy_ok,
                           output logic [1:0] sp0, output logic [1:0] sp2,
                           output bit ov_next, output bit rdy_next);
        @(negedge clk); step_valid = 1'b1; spike_in = s;
        @(posedge clk); #1; step_valid = 1'b0; spike_in = '0;
        wait_done(lat, busy_ok, sp0, sp2);
        @(posedge clk); #1;
        ov_next = b0.out_valid; rdy_next = b0.step_ready;
    endtask

    initial begin
        int lat, cnt, ov_edge;
        bit busy_ok, ov_next, rdy_next;
        logic [1:0] sp0, sp2;

        //            rst we wi wj   wd  stp sin     e0     c2 e2     cv vj  ev
        tbl[0]  = '{1, 0, 0, 0,    0, 1, 3'b111, 2'b00, 0, 2'b00, 0, 0,    0};
        tbl[1]  = '{1, 1, 0, 0,    3, 0, 3'b000, 2'b00, 0, 2'b00, 0, 0,    0};
        tbl[2]  = '{0, 1, 1, 0,    3, 0, 3'b000, 2'b00, 0, 2'b00, 0, 0,    0};
        tbl[3]  = '{0, 1, 2, 0,    2, 0, 3'b000, 2'b00, 0, 2'b00, 0, 0,    0};
        tbl[4]  = '{0, 0, 0, 0,    0, 1, 3'b111, 2'b01, 0, 2'b00, 1, 0,    0};
        tbl[5]  = '{1, 1, 2, 1,    4, 0, 3'b000, 2'b00, 0, 2'b00, 0, 0,    0};
        tbl[6]  = '{0, 0, 0, 0,    0, 1, 3'b100, 2'b00, 0, 2'b00, 1, 1,    4};
        tbl[7]  = '{0, 0, 0, 0,    0, 1, 3'b100, 2'b00, 0, 2'b00, 1, 1,    6};
        tbl[8]  = '{0, 0, 0, 0,    0, 1, 3'b100, 2'b00, 0, 2'b00, 1, 1,    7};
        tbl[9]  = '{0, 0, 0, 0,    0, 1, 3'b100, 2'b10, 0, 2'b00, 1, 1,    0};
        tbl[10] = '{1, 1, 0, 0, -128, 0, 3'b000, 2'b00, 0, 2'b00, 0, 0,    0};
        tbl[11] = '{0, 1, 1, 0, -128, 0, 3'b000, 2'b00, 0, 2'b00, 0, 0,    0};
        tbl[12] = '{0, 1, 2, 0, -128, 0, 3'b000, 2'b00, 0, 2'b00, 0, 0,    0};
        tbl[13] = '{0, 0, 0, 0,    0, 1, 3'b111, 2'b00, 0, 2'b00, 1, 0, -128};
        tbl[14] = '{0, 0, 0, 0,    0, 1, 3'b000, 2'b00, 0, 2'b00, 1, 0,  -64};
        tbl[15] = '{1, 1, 0, 0,    3, 0, 3'b000, 2'b00, 0, 2'b00, 0, 0,    0};
        tbl[16] = '{0, 1, 1, 0,    3, 0, 3'b000, 2'b00, 0, 2'b00, 0, 0,    0};
        tbl[17] = '{0, 1, 2, 0,    2, 1, 3'b111, 2'b01, 1, 2'b01, 0, 0,    0};
        tbl[18] = '{0, 0, 0, 0,    0, 1, 3'b111, 2'b01, 1, 2'b00, 0, 0,    0};
        tbl[19] = '{0, 0, 0, 0,    0, 1, 3'b111, 2'b01, 1, 2'b00, 0, 0,    0};
        tbl[20] = '{0, 0, 0, 0,    0, 1, 3'b111, 2'b01, 1, 2'b01, 0, 0,    0};
        tbl[21] = '{0, 0, 0, 0,    0, 1, 3'b111, 2'b01, 1, 2'b00, 0, 0,    0};

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset step_ready", int'(b0.step_ready), 1);
        chk("reset out_valid", int'(b0.out_valid), 0);
        chk("reset spike_out", int'(b0.spike_out), 0);

        for (int n = 0; n < NV; n++) begin
            if (tbl[n].rst) pulse_rst();
            if (tbl[n].we) wr(tbl[n].wi, tbl[n].wj, tbl[n].wd);
            if (tbl[n].step) begin
                do_step(tbl[n].sin, lat, busy_ok, sp0, sp2, ov_next, rdy_next);
                chk($sformatf("row%0d latency", n), lat, L);
                chk($sformatf("row%0d ready_low_while_busy", n), int'(busy_ok), 1);
                chk($sformatf("row%0d spike_out", n), int'(sp0), int'(tbl[n].exp0));
                chk($sformatf("row%0d out_valid_one_cycle", n), int'(ov_next), 0);
                chk($sformatf("row%0d ready_after", n), int'(rdy_next), 1);
                if (tbl[n].chk2)
                    chk($sformatf("row%0d spike_out_refrac", n), int'(sp2), int'(tbl[n].exp2));
                if (tbl[n].chkv)
                    chk($sformatf("row%0d v[%0d]", n, tbl[n].vj), int'(dut0.v[tbl[n].vj]), tbl[n].expv);
            end
        end

        // Write and step_valid while busy are both ignored
        pulse_rst();
        @(negedge clk); step_valid = 1'b1; spike_in = 3'b111;
        @(posedge clk); #1; step_valid = 1'b0; spike_in = '0;
        cnt = 0; ov_edge = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            w_we = (k == 1); w_addr_in = 2'd0; w_addr_out = 1'd0; w_data = 8'd8;
            step_valid = (k == 2 || k == 3); spike_in = 3'b001;
            @(posedge clk); #1;
            if (b0.out_valid) begin
                cnt++;
                if (ov_edge < 0) ov_edge = k;
            end
        end
        w_we = 1'b0; step_valid = 1'b0; spike_in = '0;
        chk("busy out_valid count", cnt, 1);
        chk("busy out_valid edge", ov_edge, L);
        do_step(3'b001, lat, busy_ok, sp0, sp2, ov_next, rdy_next);
        chk("busy write ignored spike_out", int'(sp0), 0);

        // Reset on the 3rd edge after accept aborts the step and clears the weights
        pulse_rst();
        wr(0, 0, 8);
        @(negedge clk); step_valid = 1'b1; spike_in = 3'b001;
        @(posedge clk); #1; step_valid = 1'b0; spike_in = '0;
        cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk); rst = (k == 3);
            @(posedge clk); #1;
            if (b0.out_valid) cnt++;
            if (k == 3) chk("abort step_ready", int'(b0.step_ready), 1);
        end
        rst = 1'b0;
        chk("abort out_valid count", cnt, 0);
        do_step(3'b001, lat, busy_ok, sp0, sp2, ov_next, rdy_next);
        chk("abort latency", lat, L);
        chk("abort weights cleared spike_out", int'(sp0), 0);

        // Write on the accepting edge: this step uses the old weight, the next one the new
        pulse_rst();
        @(negedge clk);
        w_we = 1'b1; w_addr_in = 2'd0; w_addr_out = 1'd0; w_data = 8'd8;
        step_valid = 1'b1; spike_in = 3'b001;
        @(posedge clk); #1;
        w_we = 1'b0; step_valid = 1'b0; spike_in = '0;
        wait_done(lat, busy_ok, sp0, sp2);
        chk("same_edge latency", lat, L);
        chk("same_edge old weight spike_out", int'(sp0), 0);
        do_step(3'b001, lat, busy_ok, sp0, sp2, ov_next, rdy_next);
        chk("same_edge new weight spike_out", int'(sp0), 1);

        // Out-of-range input address is ignored
        wr(3, 1, 8);
        do_step(3'b111, lat, busy_ok, sp0, sp2, ov_next, rdy_next);
        chk("oob write ignored spike_out", int'(sp0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
